// File: rtl/uart_frame_packer.sv
// Frames ADC bytes drained from the DataStorage FIFO as SYNC, SEQ, LEN, payload, CSUM
// and hands them one at a time to the TxDWrapper UART channel.
module uart_frame_packer #(
    parameter int         PAYLOAD_LEN = 64,
    parameter logic [7:0] SYNC_BYTE   = 8'hAA,
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         TIMEOUT     = 1000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        FifoReadyToSend,
    output logic        FifoReadEnable,
    input  logic        FifoDataValid,
    input  logic [7:0]  FifoData,
    input  logic        TxBusy,
    output logic        TxLatch,
    output logic [7:0]  TxData,
    output logic        FrameActive,
    output logic        Underrun,
    output logic [15:0] FrameCount
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      LEN_BYTE = 8'(PAYLOAD_LEN);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_CSUM
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      seq_cnt;
    logic [7:0]      csum_acc;
    logic [7:0]      pay_idx;
    logic [7:0]      pay_byte;
    logic [7:0]      tx_data_q;
    logic [7:0]      cur_byte;
    logic [7:0]      idx_next;
    logic [TO_W-1:0] timeout_cnt;
    logic            pad_flag;
    logic            latch_prev;
    logic            send_state;
    logic [15:0]     frame_count_q;

    // A byte goes out only when the UART is idle and we did not latch last cycle,
    // which hides a TxBusy that rises one cycle late.
    always_comb begin
        send_state = (state == ST_SYNC) || (state == ST_SEQ) || (state == ST_LEN) ||
                     (state == ST_SEND) || (state == ST_CSUM);
        TxLatch    = send_state && !TxBusy && !latch_prev;
        idx_next   = pay_idx + 8'd1;
        case (state)
            ST_SYNC: cur_byte = SYNC_BYTE;
            ST_SEQ:  cur_byte = seq_cnt;
            ST_LEN:  cur_byte = LEN_BYTE;
            ST_SEND: cur_byte = pad_flag ? PAD_BYTE : pay_byte;
            ST_CSUM: cur_byte = ~csum_acc + 8'd1;
            default: cur_byte = 8'h00;
        endcase
        TxData      = TxLatch ? cur_byte : tx_data_q;
        FrameActive = (state != ST_IDLE);
        FrameCount  = frame_count_q;
    end

    always_comb begin
        state_next     = state;
        FifoReadEnable = 1'b0;
        Underrun       = 1'b0;
        case (state)
            ST_IDLE: if (Enable && FifoReadyToSend) state_next = ST_SYNC;
            ST_SYNC: if (TxLatch) state_next = ST_SEQ;
            ST_SEQ:  if (TxLatch) state_next = ST_LEN;
            ST_LEN:  if (TxLatch) state_next = ST_REQ;
            ST_REQ: begin
                if (FifoReadyToSend) begin
                    FifoReadEnable = 1'b1;
                    state_next     = ST_WAIT;
                end else if (timeout_cnt == TO_LAST) begin
                    // This is the TIMEOUT-th empty cycle: pad out the rest of the frame.
                    Underrun   = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_WAIT: if (FifoDataValid) state_next = ST_SEND;
            ST_SEND: begin
                if (TxLatch) begin
                    if (idx_next == LEN_BYTE) state_next = ST_CSUM;
                    else if (pad_flag)        state_next = ST_SEND;
                    else                      state_next = ST_REQ;
                end
            end
            ST_CSUM: if (TxLatch) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ST_IDLE;
            seq_cnt       <= 8'h00;
            csum_acc      <= 8'h00;
            pay_idx       <= 8'h00;
            pay_byte      <= 8'h00;
            tx_data_q     <= 8'h00;
            timeout_cnt   <= '0;
            pad_flag      <= 1'b0;
            latch_prev    <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            state      <= state_next;
            latch_prev <= TxLatch;
            if (TxLatch) tx_data_q <= cur_byte;
            case (state)
                ST_IDLE: begin
                    if (state_next == ST_SYNC) begin
                        csum_acc <= 8'h00;
                        pay_idx  <= 8'h00;
                        pad_flag <= 1'b0;
                    end
                end
                ST_SEQ, ST_LEN: if (TxLatch) csum_acc <= csum_acc + cur_byte;
                ST_REQ: begin
                    if (FifoReadyToSend) begin
                        timeout_cnt <= '0;
                    end else if (Underrun) begin
                        timeout_cnt <= '0;
                        pad_flag    <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_WAIT: if (FifoDataValid) pay_byte <= FifoData;
                ST_SEND: begin
                    if (TxLatch) begin
                        csum_acc <= csum_acc + cur_byte;
                        pay_idx  <= idx_next;
                    end
                end
                ST_CSUM: begin
                    if (TxLatch) begin
                        seq_cnt       <= seq_cnt + 8'd1;
                        frame_count_q <= frame_count_q + 16'd1;
                        pad_flag      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Self-checking bench for uart_frame_packer with a FIFO model, a UART busy model and
// a byte scoreboard filled from a frame model whenever a frame is requested.
module tb_uart_frame_packer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        FifoReadyToSend = 1'b0;
    logic        FifoReadEnable;
    logic        FifoDataValid = 1'b0;
    logic [7:0]  FifoData = 8'h00;
    logic        TxBusy = 1'b0;
    logic        TxLatch;
    logic [7:0]  TxData;
    logic        FrameActive;
    logic        Underrun;
    logic [15:0] FrameCount;

    uart_frame_packer #(
        .PAYLOAD_LEN (4),
        .SYNC_BYTE   (8'hAA),
        .PAD_BYTE    (8'h00),
        .TIMEOUT     (8)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Enable          (Enable),
        .FifoReadyToSend (FifoReadyToSend),
        .FifoReadEnable  (FifoReadEnable),
        .FifoDataValid   (FifoDataValid),
        .FifoData        (FifoData),
        .TxBusy          (TxBusy),
        .TxLatch         (TxLatch),
        .TxData          (TxData),
        .FrameActive     (FrameActive),
        .Underrun        (Underrun),
        .FrameCount      (FrameCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] payload;
        int          nsup;
        int          busy;
        bit          lag;
        int          exp_und;
        logic [7:0]  exp_csum;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int          busy_len = 10;
    bit          busy_lag = 1'b0;
    bit          busy_hold = 1'b0;
    int          busy_left = 0;
    int          lag_left = 0;
    bit          s_latch = 1'b0;
    bit          s_rd = 1'b0;
    bit          prev_latch = 1'b0;
    bit          prev_rd = 1'b0;
    int          read_count = 0;
    int          und_count = 0;
    int          latch_count = 0;
    int          frame_pos = 0;
    logic [7:0]  frame_sum = 8'h00;
    logic [7:0]  last_byte = 8'h00;
    logic [7:0]  exp_seq = 8'h00;
    logic [15:0] exp_frames = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO answers a read one cycle later; UART goes busy for busy_len cycles per byte.
    always @(posedge Clock) begin
        if (Reset) begin
            fifo_q.delete();
            FifoDataValid   <= 1'b0;
            FifoReadyToSend <= 1'b0;
            TxBusy          <= 1'b0;
            busy_left = 0;
            lag_left  = 0;
        end else begin
            FifoDataValid <= 1'b0;
            if (s_rd && fifo_q.size() != 0) begin
                FifoData      <= fifo_q.pop_front();
                FifoDataValid <= 1'b1;
            end
            FifoReadyToSend <= (fifo_q.size() != 0);
            if (s_latch) begin
                if (busy_lag) begin
                    lag_left  = 1;
                    busy_left = 0;
                end else begin
                    busy_left = busy_len;
                end
            end else if (lag_left != 0) begin
                lag_left  = 0;
                busy_left = busy_len;
            end else if (busy_left != 0) begin
                busy_left--;
            end
            TxBusy <= busy_hold || (busy_left != 0);
        end
    end

    // Mid-cycle monitor: scoreboard, per-frame checksum and handshake rules.
    always @(negedge Clock) begin
        s_latch = TxLatch;
        s_rd    = FifoReadEnable;
        if (Reset) begin
            frame_pos  = 0;
            prev_latch = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (TxLatch) begin
                check("latch_guard", 32'({TxBusy, prev_latch}), 32'd0);
                latch_count++;
                last_byte = TxData;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", TxData);
                end else begin
                    check("tx_byte", 32'(TxData), 32'(exp_q.pop_front()));
                end
                if (frame_pos == 0) frame_sum = 8'h00;
                else frame_sum = frame_sum + TxData;
                frame_pos++;
                if (frame_pos == 8) begin
                    check("frame_sum", 32'(frame_sum), 32'd0);
                    frame_pos = 0;
                end
            end
            if (FifoReadEnable) begin
                check("one_outstanding", 32'(prev_rd), 32'd0);
                read_count++;
            end
            if (Underrun) und_count++;
            prev_latch = TxLatch;
            prev_rd    = FifoReadEnable;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic load_fifo(input logic [31:0] payload, input int nsup);
        for (int i = 0; i < nsup; i++) fifo_q.push_back(payload[8*i +: 8]);
    endtask

    task automatic push_frame(input logic [7:0] seq, input logic [31:0] payload, input int nsup);
        logic [7:0] sum;
        logic [7:0] b;
        exp_q.push_back(8'hAA);
        exp_q.push_back(seq);
        exp_q.push_back(8'd4);
        sum = seq + 8'd4;
        for (int i = 0; i < 4; i++) begin
            b = (i < nsup) ? payload[8*i +: 8] : 8'h00;
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(~sum + 8'd1);
    endtask

    task automatic wait_frames(input logic [15:0] target, input int budget, output int idle);
        int n;
        n    = 0;
        idle = 0;
        while (FrameCount != target && n < budget) begin
            tick(1);
            n++;
            if (!FrameActive) idle++;
        end
        check("frame_done", 32'(FrameCount), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txlatch"}, 32'(TxLatch), 32'd0);
        check({tag, "_txdata"}, 32'(TxData), 32'd0);
        check({tag, "_rden"}, 32'(FifoReadEnable), 32'd0);
        check({tag, "_active"}, 32'(FrameActive), 32'd0);
        check({tag, "_underrun"}, 32'(Underrun), 32'd0);
        check({tag, "_framecount"}, 32'(FrameCount), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        busy_len   = v.busy;
        busy_lag   = v.lag;
        read_count = 0;
        und_count  = 0;
        load_fifo(v.payload, v.nsup);
        push_frame(exp_seq, v.payload, v.nsup);
        Enable = 1'b1;
    endtask

    task automatic checkOutput(input vec_t v);
        int idle;
        wait_frames(exp_frames + 16'd1, 2000, idle);
        Enable     = 1'b0;
        exp_frames = exp_frames + 16'd1;
        exp_seq    = exp_seq + 8'd1;
        check("reads", 32'(read_count), 32'(v.nsup));
        check("underruns", 32'(und_count), 32'(v.exp_und));
        check("csum", 32'(last_byte), 32'(v.exp_csum));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] p;
        int          idle;
        int          n;
        int          bad;
        int          base;

        vecs[0] = '{32'h04030201, 4, 10, 1'b0, 0, 8'hF2};
        vecs[1] = '{32'h00002010, 2, 10, 1'b0, 1, 8'hCB};
        vecs[2] = '{32'hFFFFFFFF, 4, 3,  1'b0, 0, 8'hFE};
        vecs[3] = '{32'h01007F80, 4, 3,  1'b1, 0, 8'hF9};
        vecs[4] = '{32'h000000AB, 1, 2,  1'b1, 1, 8'h4D};

        Reset  = 1'b1;
        Enable = 1'b0;
        tick(3);
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_outputs("reset");
        tick(1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
            tick(2);
        end

        // TxBusy stuck high: block waits in SYNC with the previous byte still on TxData.
        busy_len   = 3;
        busy_lag   = 1'b0;
        busy_hold  = 1'b1;
        read_count = 0;
        load_fifo(32'h44332211, 4);
        push_frame(exp_seq, 32'h44332211, 4);
        Enable = 1'b1;
        tick(4);
        base = latch_count;
        bad  = 0;
        repeat (20) begin
            @(negedge Clock);
            if (TxData !== 8'h4D || FrameActive !== 1'b1) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        check("hold_latches", 32'(latch_count - base), 32'd0);
        busy_hold = 1'b0;
        wait_frames(exp_frames + 16'd1, 2000, idle);
        Enable     = 1'b0;
        exp_frames = exp_frames + 16'd1;
        exp_seq    = exp_seq + 8'd1;
        check("hold_reads", 32'(read_count), 32'd4);

        // Enable dropped mid-payload: frame finishes, no new frame despite FIFO data.
        busy_len   = 10;
        read_count = 0;
        load_fifo(32'h0D0C0B0A, 4);
        load_fifo(32'h1D1C1B1A, 4);
        push_frame(exp_seq, 32'h0D0C0B0A, 4);
        Enable = 1'b1;
        n = 0;
        while (read_count == 0 && n < 500) begin
            tick(1);
            n++;
        end
        check("drop_started", 32'(read_count != 0), 32'd1);
        Enable = 1'b0;
        wait_frames(exp_frames + 16'd1, 2000, idle);
        exp_frames = exp_frames + 16'd1;
        exp_seq    = exp_seq + 8'd1;
        bad = 0;
        repeat (30) begin
            tick(1);
            if (FrameActive) bad++;
        end
        check("drop_idle", 32'(bad), 32'd0);
        check("drop_reads", 32'(read_count), 32'd4);
        check("drop_fifo_left", 32'(fifo_q.size()), 32'd4);
        check("drop_frames", 32'(FrameCount), 32'(exp_frames));

        // Reset right after the LEN byte abandons the frame and clears SEQ and FrameCount.
        base = latch_count;
        push_frame(exp_seq, 32'h1D1C1B1A, 4);
        Enable = 1'b1;
        n = 0;
        while (latch_count < base + 3 && n < 500) begin
            tick(1);
            n++;
        end
        check("rst_len_seen", 32'(latch_count - base), 32'd3);
        Reset  = 1'b1;
        Enable = 1'b0;
        tick(1);
        @(negedge Clock);
        check_reset_outputs("midreset");
        tick(1);
        Reset = 1'b0;
        exp_q.delete();
        exp_seq    = 8'h00;
        exp_frames = 16'h0000;
        busy_len   = 4;
        read_count = 0;
        load_fifo(32'h78563412, 4);
        push_frame(exp_seq, 32'h78563412, 4);
        Enable = 1'b1;
        wait_frames(16'd1, 2000, idle);
        Enable     = 1'b0;
        exp_frames = 16'd1;
        exp_seq    = 8'd1;
        check("rst_reads", 32'(read_count), 32'd4);
        tick(2);

        // 257 back-to-back frames: SEQ wraps FF->00, one idle cycle between frames.
        busy_len = 2;
        busy_lag = 1'b0;
        for (int f = 0; f < 257; f++) begin
            p = $urandom;
            load_fifo(p, 4);
            push_frame(exp_seq + 8'(f), p, 4);
        end
        Enable = 1'b1;
        wait_frames(exp_frames + 16'd257, 20000, idle);
        Enable     = 1'b0;
        exp_frames = exp_frames + 16'd257;
        exp_seq    = exp_seq + 8'(257);
        check("wrap_gap", 32'(idle <= 260), 32'd1);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
        check("wrap_framecount", 32'(FrameCount), 32'(exp_frames));

        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
